// File: rtl/alu_exec_stage_pkg.sv
// Shared definitions for the execute stage: ALU operation encodings and FSM states.
// Decode uses the same encodings when it builds alu_op.
package alu_exec_stage_pkg;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_MUL = 3'b011;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_HOLD = 2'd2
    } exec_state_e;

    function automatic logic is_single_cycle_op(input logic [2:0] op);
        return (op == ALU_AND) || (op == ALU_OR) || (op == ALU_ADD) ||
               (op == ALU_SUB) || (op == ALU_SLT);
    endfunction

endpackage

// File: rtl/alu_exec_stage_alu24.sv
// Ripple ALU built from 1-bit slices: AND, OR, add/subtract and set-less-than.
// Slice 0 receives the signed comparison result on its Less input.
module alu_slice (
    input  logic       a_i,
    input  logic       b_i,
    input  logic       cin_i,
    input  logic       binv_i,
    input  logic       less_i,
    input  logic [1:0] op_i,
    output logic       res_o,
    output logic       sum_o,
    output logic       cout_o
);
    logic bb;

    assign bb     = b_i ^ binv_i;
    assign sum_o  = a_i ^ bb ^ cin_i;
    assign cout_o = (a_i & bb) | (a_i & cin_i) | (bb & cin_i);

    always_comb begin
        res_o = 1'b0;
        case (op_i)
            2'b00:   res_o = a_i & bb;
            2'b01:   res_o = a_i | bb;
            2'b10:   res_o = sum_o;
            default: res_o = less_i;
        endcase
    end
endmodule

module alu24 #(
    parameter int WIDTH = 24
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             binv_i,
    input  logic [1:0]       op_i,
    output logic [WIDTH-1:0] y_o,
    output logic             carry_o,
    output logic             ovf_o
);
    logic set_lt;

    // Each slice owns its carry signals so the ripple chain is not one looped vector.
    for (genvar i = 0; i < WIDTH; i++) begin : g_slice
        logic cin;
        logic cout;
        logic sum;

        if (i == 0) begin : g_first
            assign cin = binv_i;
        end else begin : g_rest
            assign cin = g_slice[i-1].cout;
        end

        alu_slice u_slice (
            .a_i    (a_i[i]),
            .b_i    (b_i[i]),
            .cin_i  (cin),
            .binv_i (binv_i),
            .less_i ((i == 0) ? set_lt : 1'b0),
            .op_i   (op_i),
            .res_o  (y_o[i]),
            .sum_o  (sum),
            .cout_o (cout)
        );
    end

    assign carry_o = g_slice[WIDTH-1].cout;
    assign ovf_o   = g_slice[WIDTH-1].cin ^ g_slice[WIDTH-1].cout;
    assign set_lt  = g_slice[WIDTH-1].sum ^ ovf_o;
endmodule

// File: rtl/alu_exec_stage.sv
// Execute stage: single-cycle ALU ops plus an iterative shift-add MUL on the shared adder.
// Handshake: a transfer happens on a clock edge where valid and ready are both high.
module alu_exec_stage
    import alu_exec_stage_pkg::*;
#(
    parameter int WIDTH  = 24,
    parameter bit MUL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       alu_op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [4:0]       rd_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [4:0]       rd_out,
    output logic             zero,
    output logic             carry,
    output logic             ovf,
    output logic             err,
    output logic [1:0]       dbg_state
);
    localparam int              CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    exec_state_e      state_q, state_d;
    logic [WIDTH-1:0] mul_a_q, mul_a_d;
    logic [WIDTH-1:0] mul_b_q, mul_b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [4:0]       rd_q, rd_d;
    logic             zero_q, zero_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;
    logic             err_q, err_d;

    logic [WIDTH-1:0] alu_a, alu_b, alu_y;
    logic [1:0]       alu_sel;
    logic             alu_binv, alu_carry, alu_ovf;
    logic             accept;

    // While multiplying, the adder computes acc + shifted multiplicand.
    always_comb begin
        alu_a    = op_a;
        alu_b    = op_b;
        alu_binv = alu_op[2];
        alu_sel  = alu_op[1:0];
        if (state_q == ST_MUL) begin
            alu_a    = acc_q;
            alu_b    = mul_a_q;
            alu_binv = 1'b0;
            alu_sel  = 2'b10;
        end
    end

    alu24 #(.WIDTH(WIDTH)) u_alu (
        .a_i     (alu_a),
        .b_i     (alu_b),
        .binv_i  (alu_binv),
        .op_i    (alu_sel),
        .y_o     (alu_y),
        .carry_o (alu_carry),
        .ovf_o   (alu_ovf)
    );

    assign in_ready = (state_q == ST_IDLE) || ((state_q == ST_HOLD) && out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d  = state_q;
        mul_a_d  = mul_a_q;
        mul_b_d  = mul_b_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        rd_d     = rd_q;
        zero_d   = zero_q;
        carry_d  = carry_q;
        ovf_d    = ovf_q;
        err_d    = err_q;
        case (state_q)
            ST_IDLE, ST_HOLD: begin
                if (accept) begin
                    rd_d = rd_in;
                    if ((alu_op == ALU_MUL) && MUL_EN) begin
                        mul_a_d = op_a;
                        mul_b_d = op_b;
                        acc_d   = '0;
                        cnt_d   = '0;
                        state_d = ST_MUL;
                    end else begin
                        state_d = ST_HOLD;
                        if (is_single_cycle_op(alu_op)) begin
                            result_d = alu_y;
                            zero_d   = (alu_y == '0);
                            carry_d  = (alu_op == ALU_ADD) || (alu_op == ALU_SUB) ||
                                       (alu_op == ALU_SLT) ? alu_carry : 1'b0;
                            ovf_d    = (alu_op == ALU_ADD) || (alu_op == ALU_SUB) ?
                                       alu_ovf : 1'b0;
                            err_d    = 1'b0;
                        end else begin
                            result_d = '0;
                            zero_d   = 1'b1;
                            carry_d  = 1'b0;
                            ovf_d    = 1'b0;
                            err_d    = 1'b1;
                        end
                    end
                end else if (state_q == ST_HOLD && out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            ST_MUL: begin
                if (mul_b_q[0]) begin
                    acc_d = alu_y;
                end
                mul_a_d = mul_a_q << 1;
                mul_b_d = mul_b_q >> 1;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d  = ST_HOLD;
                    result_d = acc_d;
                    zero_d   = (acc_d == '0);
                    carry_d  = 1'b0;
                    ovf_d    = 1'b0;
                    err_d    = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            mul_a_q  <= '0;
            mul_b_q  <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            rd_q     <= '0;
            zero_q   <= 1'b0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            mul_a_q  <= mul_a_d;
            mul_b_q  <= mul_b_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            rd_q     <= rd_d;
            zero_q   <= zero_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
            err_q    <= err_d;
        end
    end

    assign out_valid = (state_q == ST_HOLD);
    assign result    = result_q;
    assign rd_out    = rd_q;
    assign zero      = zero_q;
    assign carry     = carry_q;
    assign ovf       = ovf_q;
    assign err       = err_q;
    assign dbg_state = state_q;
endmodule
